sec_encoder_28bits_clk: RTL
===========================

Name: sec_encoder_28bits_clk

Overview:
Multi-cycle SEC encoder that sits directly upstream of the 28-bit SEC location decoder. It takes a 28-bit data word through a valid/ready handshake and computes 8 check bits, processing BITS_PER_CYCLE data bits per clock. It presents the 36-bit codeword W = {C[7:0], D[27:0]}, the same word format the decoder consumes.

Parameters:
DATA_BITS, 28, data word width; fixed for this codeword format.
CHK_BITS, 8, check-bit width; W width = DATA_BITS + CHK_BITS = 36.
BITS_PER_CYCLE, 4, data bits folded per ENC cycle; must divide DATA_BITS; legal values 1, 2, 4, 7, 14, 28.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  D is valid.
in_ready  output  1  encoder can accept; high only in IDLE.
D  input  28  data word, sampled on the accept edge.
out_valid  output  1  W is valid; held until consumed.
out_ready  input  1  downstream accepts W.
W  output  36  codeword {C[7:0], D[27:0]}.
busy  output  1  high in ENC or DONE.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, W=0, internal accumulator=0, bit counter=0. Reset asserted mid-ENC or mid-DONE aborts the word; no partial output is produced.
- Column code h_i for data bit i (0..27): the i-th integer ≥3 that is not a power of two. Sequence: 3,5,6,7,9..15,17..31,33,34, so h_0=3 and h_27=34. Each h_i is 6 bits.
- Check bits:
  - C[5:0] = XOR of h_i over all i with D[i]=1.
  - C[6] = XOR of D[27:0].
  - C[7] = XOR of C[6:0].
- FSM:
  - IDLE: if in_valid, the word is accepted on this edge (edge E0). D is latched, the accumulator and counter are cleared, and the state moves to ENC.
  - ENC: each edge folds bits [cnt*BPC +: BPC] into the accumulator and increments cnt. After DATA_BITS/BPC edges (7 at default, edges E1..E7), C[7:6] are finalised, W is loaded and the state moves to DONE.
  - DONE: out_valid=1 and W is held stable. On an edge with out_ready=1, out_valid is cleared and the state moves to IDLE. out_ready is ignored in all other states.
- Latency: out_valid goes high after edge E(DATA_BITS/BPC), i.e. 7 cycles after the accept edge at default. A word whose out_ready is high on arrival completes in 8 cycles. Next accept is possible at the earliest 9 edges after the previous accept.
- in_ready = (state==IDLE). in_valid is ignored outside IDLE. D may change freely after the accept edge.
- Back-pressure: when out_ready stays low, DONE persists indefinitely with W unchanged.
- W keeps the last codeword after the DONE→IDLE transition and changes only on the next ENC completion.
- BPC=28 degenerates to a single ENC cycle. Latency is then 1 cycle.

Test Plan:
- Reset mid-ENC: accept D=0xFFFFFFF, pulse rst_n low at edge E3 -> out_valid=0, W=0, in_ready=1 immediately; no codeword is ever produced.
- All-ones: D=0xFFFFFFF, out_ready=1 -> W=0x9CFFFFFFF, with out_valid high exactly 7 cycles after the accept edge for one cycle; busy high 8 cycles.
- Single-bit boundaries:
  - D=0x0000001 -> W=0xC30000001.
  - D=0x8000000 -> W=0xE28000000.
  - D=0 -> W=0x000000000.
- Back-pressure: D=0x0000001, out_ready low for 20 cycles then high -> W stable and out_valid high throughout; in_ready stays 0 until the cycle after release. in_valid pulses during DONE are dropped.
- Back-to-back with decoder: stream 100 random D words, and their single-bit-error variants, into the downstream decoder -> decoder reports correct location/recovered data for every word, and the encoder never asserts in_ready and out_valid together.

Source files
------------

// File: rtl/sec_encoder_28bits_clk.sv
// sec_encoder_28bits_clk: multi-cycle SEC encoder producing W = {C[7:0], D[27:0]}.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/D accept a data word;
// out_valid/out_ready/W present the codeword; busy is high while encoding or holding W.
module sec_encoder_28bits_clk #(
    parameter int DATA_BITS      = 28,
    parameter int CHK_BITS       = 8,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_BITS-1:0]          D,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_BITS+CHK_BITS-1:0] W,
    output logic                          busy
);
    localparam int STEPS = DATA_BITS / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);
    typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;
    state_t                          state_q, state_d;
    logic [DATA_BITS-1:0]            d_q, d_d;
    logic [6:0]                      acc_q, acc_d, acc_nx, fold;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [DATA_BITS+CHK_BITS-1:0]   w_q, w_d;
    // Column code of data bit idx: the idx-th integer >= 3 that is not a power of two.
    function automatic logic [5:0] h_of(input int idx);
        logic [5:0] r;
        int k;
        r = '0;
        k = 0;
        for (int v = 3; v < 64; v++) begin
            if ((v & (v - 1)) != 0) begin
                if (k == idx) r = 6'(v);
                k++;
            end
        end
        return h_of_ret(r);
    endfunction
    function automatic logic [5:0] h_of_ret(input logic [5:0] r);
        return r;
    endfunction
    always_comb begin
        // acc[6] carries the running data parity alongside the 6-bit column syndrome
        fold = '0;
        for (int i = 0; i < DATA_BITS; i++)
            if (cnt_q == CNT_W'(i / BITS_PER_CYCLE) && d_q[i]) fold = fold ^ {1'b1, h_of(i)};
        acc_nx  = acc_q ^ fold;
        state_d = state_q;
        d_d     = d_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        case (state_q)
            IDLE: if (in_valid) begin
                d_d     = D;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ENC;
            end
            ENC: begin
                acc_d = acc_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    w_d     = {^acc_nx, acc_nx, d_q};
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
        end
    end
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign W         = w_q;
endmodule
